// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweeper: steps x through 0..15, holds each pattern HOLD_CYCLES
// cycles, samples y on the last edge of each hold window and builds truth/ones_count.
module truth_table_sweeper #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y,
  output logic [3:0]  x,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth,
  output logic [4:0]  ones_count
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;

  state_t         state, state_next;
  logic [HCW-1:0] hold_cnt;
  logic           capture;

  always_comb begin
    capture    = (state == DRIVE) && (hold_cnt == HOLD_LAST);
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   if (capture && (x == 4'hF)) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered copies of the next state so they align with state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == DRIVE);
      done  <= (state_next == FIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= 4'd0;
      hold_cnt   <= '0;
      truth      <= 16'h0000;
      ones_count <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x          <= 4'd0;
            hold_cnt   <= '0;
            truth      <= 16'h0000;
            ones_count <= 5'd0;
          end
        end
        DRIVE: begin
          if (capture) begin
            truth[x]   <= y;
            ones_count <= ones_count + {4'd0, y};
            hold_cnt   <= '0;
            // pattern 15 is the last one; x parks at 0 instead of wrapping into a new pass
            if (x == 4'hF) x <= 4'd0;
            else           x <= x + 4'd1;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        FIN: x <= 4'd0;
        default: x <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (HOLD_CYCLES 20 and 1) driven by
// random truth tables, compared against a table-lookup reference model.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n, start_a, start_b;
  logic [15:0] tbl_a, tbl_b;
  logic [3:0]  x_a, x_b;
  logic        busy_a, busy_b, done_a, done_b, y_a, y_b;
  logic [15:0] truth_a, truth_b;
  logic [4:0]  ones_a, ones_b;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // the "logic block under sweep" is a lookup of the chosen table
  assign y_a = tbl_a[x_a];
  assign y_b = tbl_b[x_b];

  truth_table_sweeper #(.HOLD_CYCLES(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y(y_a), .x(x_a),
    .busy(busy_a), .done(done_a), .truth(truth_a), .ones_count(ones_a));

  truth_table_sweeper #(.HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y(y_b), .x(x_b),
    .busy(busy_b), .done(done_b), .truth(truth_b), .ones_count(ones_b));

  function automatic int ref_ones(input logic [15:0] t);
    int n = 0;
    for (int i = 0; i < 16; i++) if (t[i]) n++;
    return n;
  endfunction

  // Runs one sweep on instance sel; reports cycles from the accepting edge to done,
  // x/busy sequence errors during DRIVE, and the captured results.
  task automatic run_sweep(input bit sel, input int pulse_at, output int cycles,
                           output int xerr, output logic [15:0] tr, output logic [4:0] oc);
    int h;
    int j;
    bit got;
    h = sel ? 1 : 20;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    j = 0; got = 0; xerr = 0; cycles = -1;
    tr = 16'hxxxx; oc = 5'bx;
    while (j < 16*h + 8 && !got) begin
      if (sel) start_b = (j == pulse_at); else start_a = (j == pulse_at);
      if (sel ? done_b : done_a) begin
        got = 1; cycles = j;
        tr = sel ? truth_b : truth_a;
        oc = sel ? ones_b : ones_a;
      end else begin
        if ((sel ? x_b : x_a) !== 4'(j / h) || (sel ? busy_b : busy_a) !== 1'b1) xerr++;
        j++;
        @(negedge clk);
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    if (!got) begin
      tr = sel ? truth_b : truth_a;
      oc = sel ? ones_b : ones_a;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; tbl_a = '0; tbl_b = '0;
    repeat (2) @(negedge clk);
    total_cnt++; if ({x_a, busy_a, done_a} !== 6'd0) $display("FAIL reset_ctrl_a: got %b want 0", {x_a, busy_a, done_a}); else pass_cnt++;
    total_cnt++; if ({truth_a, ones_a} !== 21'd0) $display("FAIL reset_data_a: got %h want 0", {truth_a, ones_a}); else pass_cnt++;
    total_cnt++; if ({x_b, busy_b, done_b} !== 6'd0) $display("FAIL reset_ctrl_b: got %b want 0", {x_b, busy_b, done_b}); else pass_cnt++;
    total_cnt++; if ({truth_b, ones_b} !== 21'd0) $display("FAIL reset_data_b: got %h want 0", {truth_b, ones_b}); else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if ({x_a, busy_a, done_a, x_b, busy_b, done_b} !== 12'd0) $display("FAIL idle_after_reset: got %b want 0", {x_a, busy_a, done_a, x_b, busy_b, done_b}); else pass_cnt++;
  endtask

  task automatic test_parity();
    int c, xe; logic [15:0] tr; logic [4:0] oc;
    for (int i = 0; i < 16; i++) tbl_a[i] = ^(4'(i));
    run_sweep(1'b0, -1, c, xe, tr, oc);
    total_cnt++; if (tr !== 16'h6996) $display("FAIL parity_truth: got %h want 6996", tr); else pass_cnt++;
    total_cnt++; if (oc !== 5'd8) $display("FAIL parity_ones: got %0d want 8", oc); else pass_cnt++;
    total_cnt++; if (c !== 320) $display("FAIL parity_latency: got %0d want 320 edges after accept", c); else pass_cnt++;
    total_cnt++; if (xe !== 0) $display("FAIL parity_xseq: got %0d errors want 0", xe); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({done_a, busy_a} !== 2'b00) $display("FAIL parity_done_one_cycle: got %b want 00", {done_a, busy_a}); else pass_cnt++;
    total_cnt++; if (truth_a !== 16'h6996) $display("FAIL parity_hold: got %h want 6996", truth_a); else pass_cnt++;
  endtask

  task automatic test_constant();
    int c, xe; logic [15:0] tr; logic [4:0] oc;
    tbl_a = 16'h0000;
    run_sweep(1'b0, -1, c, xe, tr, oc);
    total_cnt++; if ({tr, oc} !== 21'd0) $display("FAIL const0: got %h/%0d want 0000/0", tr, oc); else pass_cnt++;
    tbl_a = 16'hFFFF;
    run_sweep(1'b0, -1, c, xe, tr, oc);
    total_cnt++; if (tr !== 16'hFFFF) $display("FAIL const1_truth: got %h want ffff", tr); else pass_cnt++;
    total_cnt++; if (oc !== 5'd16) $display("FAIL const1_ones: got %0d want 16", oc); else pass_cnt++;
  endtask

  task automatic test_fast_minterm();
    int c, xe; logic [15:0] tr; logic [4:0] oc;
    tbl_b = 16'h8000;
    run_sweep(1'b1, -1, c, xe, tr, oc);
    total_cnt++; if ({tr, oc} !== {16'h8000, 5'd1}) $display("FAIL fast_result: got %h/%0d want 8000/1", tr, oc); else pass_cnt++;
    total_cnt++; if (c !== 16) $display("FAIL fast_latency: got %0d want 16 edges after accept", c); else pass_cnt++;
    total_cnt++; if (xe !== 0) $display("FAIL fast_xseq: got %0d errors want 0", xe); else pass_cnt++;
  endtask

  task automatic test_random();
    int c, xe; logic [15:0] tr; logic [4:0] oc;
    for (int k = 0; k < 8; k++) begin
      bit sel;
      sel = (k >= 2);
      if (sel) tbl_b = 16'($urandom); else tbl_a = 16'($urandom);
      run_sweep(sel, -1, c, xe, tr, oc);
      total_cnt++;
      if (tr !== (sel ? tbl_b : tbl_a) || oc !== 5'(ref_ones(sel ? tbl_b : tbl_a)) || xe !== 0 || c !== (sel ? 16 : 320))
        $display("FAIL random_%0d: got %h/%0d/c%0d/xe%0d want %h/%0d", k, tr, oc, c, xe, sel ? tbl_b : tbl_a, ref_ones(sel ? tbl_b : tbl_a));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int times[$]; int bad_int, bad_tr, c, xe; logic [15:0] tr; logic [4:0] oc;
    tbl_b = 16'($urandom); bad_int = 0; bad_tr = 0;
    @(negedge clk); start_b = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (done_b) begin
        times.push_back(cyc);
        if (truth_b !== tbl_b || ones_b !== 5'(ref_ones(tbl_b))) bad_tr++;
      end
    end
    start_b = 1'b0;
    repeat (30) @(negedge clk);
    for (int i = 1; i < times.size(); i++) if (times[i] - times[i-1] != 18) bad_int++;
    total_cnt++; if (times.size() < 5) $display("FAIL b2b_pulses: got %0d want >=5", times.size()); else pass_cnt++;
    total_cnt++; if (bad_int !== 0) $display("FAIL b2b_period: got %0d bad intervals want 0", bad_int); else pass_cnt++;
    total_cnt++; if (bad_tr !== 0) $display("FAIL b2b_truth: got %0d bad results want 0", bad_tr); else pass_cnt++;
    tbl_a = 16'($urandom);
    run_sweep(1'b0, 100, c, xe, tr, oc);
    total_cnt++; if (xe !== 0 || c !== 320 || tr !== tbl_a) $display("FAIL mid_drive_start: got xe%0d c%0d %h want 0/320/%h", xe, c, tr, tbl_a); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, dn, c, xe; logic [15:0] tr; logic [4:0] oc;
    tbl_a = 16'hFFFF; n = 0; dn = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    while (x_a !== 4'd7 && n < 400) begin @(negedge clk); n++; end
    total_cnt++; if (x_a !== 4'd7) $display("FAIL reach_x7: got %0d want 7", x_a); else pass_cnt++;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({x_a, busy_a} !== 5'd0) $display("FAIL async_ctrl: got %b want 0", {x_a, busy_a}); else pass_cnt++;
    total_cnt++; if ({truth_a, ones_a} !== 21'd0) $display("FAIL async_data: got %h/%0d want 0/0", truth_a, ones_a); else pass_cnt++;
    repeat (3) begin @(negedge clk); if (done_a) dn++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done_a || busy_a) dn++; end
    total_cnt++; if (dn !== 0) $display("FAIL abort_no_done: got %0d done/busy samples want 0", dn); else pass_cnt++;
    tbl_a = 16'($urandom);
    run_sweep(1'b0, -1, c, xe, tr, oc);
    total_cnt++; if (tr !== tbl_a || oc !== 5'(ref_ones(tbl_a)) || c !== 320) $display("FAIL after_reset_sweep: got %h/%0d/c%0d want %h/%0d", tr, oc, c, tbl_a, ref_ones(tbl_a)); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_parity();
    test_constant();
    test_fast_minterm();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
